// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_pkg
// Description : Shared SDRAM command encodings, arbiter state encodings and
//               timing defaults for the single-bank SDRAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_pkg;

    // SDRAM commands, encoded as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;

    // Timing defaults (50 MHz sclk)
    localparam int REF_PERIOD_DEF  = 750;
    localparam int TRFC_CYCLES_DEF = 4;
    localparam int REF_CNT_W       = 13;

    // One-hot arbiter states
    typedef enum logic [4:0] {
        S_INIT  = 5'b00001,
        S_ARBIT = 5'b00010,
        S_AREF  = 5'b00100,
        S_WRITE = 5'b01000,
        S_READ  = 5'b10000
    } arb_state_t;

    // Most recent data-path owner, used for round-robin tie breaking
    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_t;

endpackage : sdram_pkg
`default_nettype wire

// File: rtl/sdram_ref_timer.sv
`default_nettype none
// ============================================================================
// Module      : sdram_ref_timer
// Description : Auto-refresh interval timer. Counts while the controller is
//               out of init, saturates at REF_PERIOD-1 and holds ref_req
//               until the arbiter acknowledges by entering auto-refresh.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_ref_timer
    import sdram_pkg::*;
#(
    parameter int REF_PERIOD = REF_PERIOD_DEF
) (
    input  logic sclk,
    input  logic s_rst_n,
    input  logic run,
    input  logic ref_ack,
    output logic ref_req
);

    localparam logic [REF_CNT_W-1:0] C_CNT_MAX = REF_CNT_W'(REF_PERIOD - 1);

    logic [REF_CNT_W-1:0] r_cnt;
    logic                 r_ref_req;

    // Interval counter: cleared in init and on refresh entry, saturates at the top
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_cnt <= '0;
        end else if (!run || ref_ack) begin
            r_cnt <= '0;
        end else if (r_cnt != C_CNT_MAX) begin
            r_cnt <= r_cnt + REF_CNT_W'(1);
        end
    end

    // Refresh request: the acknowledge wins over a simultaneous set
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_ref_req <= 1'b0;
        end else if (!run || ref_ack) begin
            r_ref_req <= 1'b0;
        end else if (r_cnt == C_CNT_MAX) begin
            r_ref_req <= 1'b1;
        end
    end

    assign ref_req = r_ref_req;

endmodule : sdram_ref_timer
`default_nettype wire

// File: rtl/sdram_arbit.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbit
// Description : Top-level SDRAM bus scheduler. Sequences init, auto-refresh,
//               write and read onto the single command/address port with
//               priority refresh > {write, read}; write and read alternate
//               when both are pending.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int         REF_PERIOD  = REF_PERIOD_DEF,
    parameter int         TRFC_CYCLES = TRFC_CYCLES_DEF,
    parameter logic [3:0] CMD_NOP     = sdram_pkg::CMD_NOP,
    parameter logic [3:0] CMD_AREF    = sdram_pkg::CMD_AREF
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic [3:0]  init_cmd,
    input  logic [12:0] init_addr,
    input  logic        flag_init_end,
    input  logic        wr_trig_req,
    input  logic [3:0]  wr_cmd,
    input  logic [12:0] wr_addr,
    input  logic [1:0]  wr_bank,
    input  logic        flag_wr_end,
    input  logic        rd_trig_req,
    input  logic [3:0]  rd_cmd,
    input  logic [12:0] rd_addr,
    input  logic [1:0]  rd_bank,
    input  logic        flag_rd_end,
    output logic        wr_en,
    output logic        rd_en,
    output logic        ref_req,
    output logic        sdram_cke,
    output logic [3:0]  sdram_cmd,
    output logic [12:0] sdram_addr,
    output logic [1:0]  sdram_bank
);

    // Wide enough to hold TRFC_CYCLES itself, so the count never wraps early
    localparam int AREF_W = $clog2(TRFC_CYCLES + 1);
    localparam logic [AREF_W-1:0] C_AREF_LAST = AREF_W'(TRFC_CYCLES - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    grant_t            r_last_grant;
    logic [AREF_W-1:0] r_aref_cnt;
    logic              r_wr_en;
    logic              r_rd_en;
    logic              w_ref_req;
    logic              w_ref_ack;
    logic              w_run;
    logic              w_wr_enter;
    logic              w_rd_enter;

    assign w_run      = (r_state != S_INIT);
    assign w_ref_ack  = (r_state == S_ARBIT) && (w_state_nxt == S_AREF);
    assign w_wr_enter = (r_state == S_ARBIT) && (w_state_nxt == S_WRITE);
    assign w_rd_enter = (r_state == S_ARBIT) && (w_state_nxt == S_READ);

    sdram_ref_timer #(
        .REF_PERIOD (REF_PERIOD)
    ) u_ref_timer (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .run     (w_run),
        .ref_ack (w_ref_ack),
        .ref_req (w_ref_req)
    );

    // State register
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; requests and refresh are only considered in S_ARBIT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT: begin
                if (flag_init_end) w_state_nxt = S_ARBIT;
            end
            S_ARBIT: begin
                if (w_ref_req) begin
                    w_state_nxt = S_AREF;
                end else if (wr_trig_req && rd_trig_req) begin
                    w_state_nxt = (r_last_grant == GRANT_READ) ? S_WRITE : S_READ;
                end else if (wr_trig_req) begin
                    w_state_nxt = S_WRITE;
                end else if (rd_trig_req) begin
                    w_state_nxt = S_READ;
                end
            end
            S_AREF: begin
                if (r_aref_cnt == C_AREF_LAST) w_state_nxt = S_ARBIT;
            end
            S_WRITE: begin
                if (flag_wr_end) w_state_nxt = S_ARBIT;
            end
            S_READ: begin
                if (flag_rd_end) w_state_nxt = S_ARBIT;
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    // Cycle counter inside auto-refresh; zero everywhere else
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_aref_cnt <= '0;
        end else if ((r_state == S_AREF) && (r_aref_cnt != C_AREF_LAST)) begin
            r_aref_cnt <= r_aref_cnt + AREF_W'(1);
        end else begin
            r_aref_cnt <= '0;
        end
    end

    // One-cycle grant pulses and round-robin memory, updated on grant entry
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_wr_en      <= 1'b0;
            r_rd_en      <= 1'b0;
            r_last_grant <= GRANT_READ;
        end else begin
            r_wr_en <= w_wr_enter;
            r_rd_en <= w_rd_enter;
            if (w_wr_enter) begin
                r_last_grant <= GRANT_WRITE;
            end else if (w_rd_enter) begin
                r_last_grant <= GRANT_READ;
            end
        end
    end

    // Bus mux; reset forces NOP immediately rather than passing init_cmd
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_bank = '0;
        if (s_rst_n) begin
            case (r_state)
                S_INIT: begin
                    sdram_cmd  = init_cmd;
                    sdram_addr = init_addr;
                end
                S_WRITE: begin
                    sdram_cmd  = wr_cmd;
                    sdram_addr = wr_addr;
                    sdram_bank = wr_bank;
                end
                S_READ: begin
                    sdram_cmd  = rd_cmd;
                    sdram_addr = rd_addr;
                    sdram_bank = rd_bank;
                end
                S_AREF: begin
                    sdram_cmd = (r_aref_cnt == '0) ? CMD_AREF : CMD_NOP;
                end
                default: begin
                    sdram_cmd = CMD_NOP;
                end
            endcase
        end
    end

    assign wr_en     = r_wr_en;
    assign rd_en     = r_rd_en;
    assign ref_req   = w_ref_req;
    assign sdram_cke = 1'b1;

endmodule : sdram_arbit
`default_nettype wire

// File: tb/tb_sdram_arbit.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_arbit
// Description : Self-checking bench for sdram_arbit: init mux, periodic
//               refresh, round-robin ties, refresh during read/write release
//               and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sdram_arbit;
    import sdram_pkg::*;

    localparam int         REF_PERIOD = 750;
    localparam int         TRFC       = 4;
    localparam logic [3:0] C_INIT_CMD = 4'b0010;
    localparam logic [3:0] C_WR_CMD   = 4'b0100;
    localparam logic [3:0] C_RD_CMD   = 4'b0101;
    localparam logic [1:0] C_WR_BANK  = 2'b01;
    localparam logic [1:0] C_RD_BANK  = 2'b10;

    logic        sclk = 1'b0;
    logic        s_rst_n;
    logic [3:0]  init_cmd;
    logic [12:0] init_addr;
    logic        flag_init_end;
    logic        wr_trig_req;
    logic [3:0]  wr_cmd;
    logic [12:0] wr_addr;
    logic [1:0]  wr_bank;
    logic        flag_wr_end;
    logic        rd_trig_req;
    logic [3:0]  rd_cmd;
    logic [12:0] rd_addr;
    logic [1:0]  rd_bank;
    logic        flag_rd_end;
    logic        wr_en;
    logic        rd_en;
    logic        ref_req;
    logic        sdram_cke;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_bank;

    sdram_arbit #(
        .REF_PERIOD  (REF_PERIOD),
        .TRFC_CYCLES (TRFC)
    ) dut (
        .sclk          (sclk),
        .s_rst_n       (s_rst_n),
        .init_cmd      (init_cmd),
        .init_addr     (init_addr),
        .flag_init_end (flag_init_end),
        .wr_trig_req   (wr_trig_req),
        .wr_cmd        (wr_cmd),
        .wr_addr       (wr_addr),
        .wr_bank       (wr_bank),
        .flag_wr_end   (flag_wr_end),
        .rd_trig_req   (rd_trig_req),
        .rd_cmd        (rd_cmd),
        .rd_addr       (rd_addr),
        .rd_bank       (rd_bank),
        .flag_rd_end   (flag_rd_end),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .ref_req       (ref_req),
        .sdram_cke     (sdram_cke),
        .sdram_cmd     (sdram_cmd),
        .sdram_addr    (sdram_addr),
        .sdram_bank    (sdram_bank)
    );

    always #5 sclk = ~sclk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Posedge counter used for latency and period measurements
    always @(posedge sclk) cyc <= cyc + 1;

    typedef struct {
        logic        is_wr;
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic [1:0]  bank;
    } grant_exp_t;

    grant_exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expect a write grant carrying this address; drive the write module bus to match
    task automatic push_wr(input logic [12:0] addr);
        grant_exp_t e;
        wr_addr = addr;
        e.is_wr = 1'b1; e.cmd = C_WR_CMD; e.addr = addr; e.bank = C_WR_BANK;
        sb.push_back(e);
    endtask

    task automatic push_rd(input logic [12:0] addr);
        grant_exp_t e;
        rd_addr = addr;
        e.is_wr = 1'b0; e.cmd = C_RD_CMD; e.addr = addr; e.bank = C_RD_BANK;
        sb.push_back(e);
    endtask

    // Scoreboard side: every grant pulse pops the next expected owner and bus
    logic prev_wr = 1'b0;
    logic prev_rd = 1'b0;
    always @(negedge sclk) begin : mon
        grant_exp_t e;
        if (s_rst_n && (wr_en || rd_en)) begin
            check("grant_exclusive", {31'd0, wr_en & rd_en}, 32'd0);
            if (sb.size() == 0) begin
                check("grant_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("grant_type", {31'd0, wr_en}, {31'd0, e.is_wr});
                check("grant_cmd", {28'd0, sdram_cmd}, {28'd0, e.cmd});
                check("grant_addr", {19'd0, sdram_addr}, {19'd0, e.addr});
                check("grant_bank", {30'd0, sdram_bank}, {30'd0, e.bank});
            end
        end
        if (wr_en) check("wr_en_width", {31'd0, prev_wr}, 32'd0);
        if (rd_en) check("rd_en_width", {31'd0, prev_rd}, 32'd0);
        prev_wr <= wr_en;
        prev_rd <= rd_en;
    end

    // Wait for a grant pulse; n = negedges waited (0 on timeout)
    task automatic wait_grant(input bit is_wr, input string tag, output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge sclk);
            if (is_wr ? wr_en : rd_en) begin
                n = i;
                break;
            end
        end
        if (n == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_ref(input string tag, output int found);
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge sclk);
            if (ref_req) begin
                found = 1;
                break;
            end
        end
        if (found == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_aref_cmd(input string tag, output int found);
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge sclk);
            if (sdram_cmd == CMD_AREF) begin
                found = 1;
                break;
            end
        end
        if (found == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Hold the granted owner for a few cycles, then pulse its end flag
    task automatic release_bus(input bit is_wr, input int hold);
        repeat (hold) begin
            @(negedge sclk);
            check(is_wr ? "wr_hold_cmd" : "rd_hold_cmd", {28'd0, sdram_cmd},
                  {28'd0, (is_wr ? C_WR_CMD : C_RD_CMD)});
        end
        if (is_wr) flag_wr_end = 1'b1; else flag_rd_end = 1'b1;
        @(negedge sclk);
        flag_wr_end = 1'b0;
        flag_rd_end = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int found;
        int t0;
        int ta1;
        int ta2;

        s_rst_n       = 1'b0;
        init_cmd      = C_INIT_CMD;
        init_addr     = 13'h0400;
        flag_init_end = 1'b0;
        wr_trig_req   = 1'b0;
        wr_cmd        = C_WR_CMD;
        wr_addr       = 13'h0000;
        wr_bank       = C_WR_BANK;
        flag_wr_end   = 1'b0;
        rd_trig_req   = 1'b0;
        rd_cmd        = C_RD_CMD;
        rd_addr       = 13'h0000;
        rd_bank       = C_RD_BANK;
        flag_rd_end   = 1'b0;

        // Reset state: NOP on the bus even though init drives a command
        repeat (3) @(negedge sclk);
        check("rst_cmd", {28'd0, sdram_cmd}, {28'd0, CMD_NOP});
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_rd_en", {31'd0, rd_en}, 32'd0);
        check("rst_ref_req", {31'd0, ref_req}, 32'd0);
        check("rst_cke", {31'd0, sdram_cke}, 32'd1);

        // Init mux
        s_rst_n = 1'b1;
        @(negedge sclk);
        check("init_cmd", {28'd0, sdram_cmd}, {28'd0, C_INIT_CMD});
        check("init_addr", {19'd0, sdram_addr}, 32'h400);
        check("init_bank", {30'd0, sdram_bank}, 32'd0);
        flag_init_end = 1'b1;
        @(negedge sclk);
        t0 = cyc;
        check("arbit_cmd", {28'd0, sdram_cmd}, {28'd0, CMD_NOP});
        check("arbit_addr", {19'd0, sdram_addr}, 32'd0);

        // Tie round-robin: WRITE first, then READ, then WRITE
        push_wr(13'h0011);
        wr_trig_req = 1'b1;
        rd_trig_req = 1'b1;
        wait_grant(1'b1, "tie_wr1", n);
        check("tie_wr1_latency", n, 32'd1);
        release_bus(1'b1, 3);
        check("tie_release_nop", {28'd0, sdram_cmd}, {28'd0, CMD_NOP});
        push_rd(13'h0122);
        wait_grant(1'b0, "tie_rd", n);
        check("tie_rd_latency", n, 32'd1);
        release_bus(1'b0, 2);
        push_wr(13'h1233);
        wait_grant(1'b1, "tie_wr2", n);
        wr_trig_req = 1'b0;
        rd_trig_req = 1'b0;
        release_bus(1'b1, 2);

        // Periodic refresh while idle
        wait_ref("ref1", found);
        if (found != 0) begin
            check("ref_rise_time", cyc - t0, REF_PERIOD);
            @(negedge sclk);
            ta1 = cyc;
            check("aref_cmd", {28'd0, sdram_cmd}, {28'd0, CMD_AREF});
            check("aref_clears_ref_req", {31'd0, ref_req}, 32'd0);
            for (int i = 1; i < TRFC; i++) begin
                @(negedge sclk);
                check("aref_nop", {28'd0, sdram_cmd}, {28'd0, CMD_NOP});
                check("aref_addr", {19'd0, sdram_addr}, 32'd0);
            end
            wait_aref_cmd("ref2", found);
            ta2 = cyc;
            check("ref_period_min", {31'd0, ((ta2 - ta1) >= REF_PERIOD)}, 32'd1);
            check("ref_period_max", {31'd0, ((ta2 - ta1) <= REF_PERIOD + TRFC + 1)}, 32'd1);
        end

        // Refresh arriving during a read: read keeps the bus until it ends
        repeat (TRFC) @(negedge sclk);
        push_rd(13'h0abc);
        rd_trig_req = 1'b1;
        wait_grant(1'b0, "rdref_grant", n);
        wait_ref("rdref_ref", found);
        check("rdref_read_holds", {28'd0, sdram_cmd}, {28'd0, C_RD_CMD});
        repeat (4) begin
            @(negedge sclk);
            check("rdref_read_holds", {28'd0, sdram_cmd}, {28'd0, C_RD_CMD});
            check("rdref_ref_pending", {31'd0, ref_req}, 32'd1);
        end
        push_rd(13'h0def);
        flag_rd_end = 1'b1;
        @(negedge sclk);
        flag_rd_end = 1'b0;
        check("rdref_release_nop", {28'd0, sdram_cmd}, {28'd0, CMD_NOP});
        @(negedge sclk);
        check("rdref_aref_first", {28'd0, sdram_cmd}, {28'd0, CMD_AREF});
        wait_grant(1'b0, "rdref_regrant", n);
        check("rdref_regrant_delay", n, TRFC + 1);
        rd_trig_req = 1'b0;
        release_bus(1'b0, 2);

        // Write released as refresh becomes pending, read waiting
        push_wr(13'h0555);
        wr_trig_req = 1'b1;
        wait_grant(1'b1, "wrref_grant", n);
        wr_trig_req = 1'b0;
        rd_trig_req = 1'b1;
        wait_ref("wrref_ref", found);
        push_rd(13'h0777);
        flag_wr_end = 1'b1;
        @(negedge sclk);
        flag_wr_end = 1'b0;
        check("wrref_release_nop", {28'd0, sdram_cmd}, {28'd0, CMD_NOP});
        @(negedge sclk);
        check("wrref_aref_before_read", {28'd0, sdram_cmd}, {28'd0, CMD_AREF});
        check("wrref_no_rd_en", {31'd0, rd_en}, 32'd0);
        wait_grant(1'b0, "wrref_read", n);
        check("wrref_read_delay", n, TRFC + 1);
        rd_trig_req = 1'b0;
        release_bus(1'b0, 2);

        // Asynchronous reset in the middle of a write
        push_wr(13'h0999);
        wr_trig_req = 1'b1;
        wait_grant(1'b1, "rst_wr_grant", n);
        @(negedge sclk);
        check("pre_rst_wr_cmd", {28'd0, sdram_cmd}, {28'd0, C_WR_CMD});
        #2;
        flag_init_end = 1'b0;
        s_rst_n = 1'b0;
        #1;
        check("async_rst_cmd", {28'd0, sdram_cmd}, {28'd0, CMD_NOP});
        check("async_rst_ref_req", {31'd0, ref_req}, 32'd0);
        check("async_rst_wr_en", {31'd0, wr_en}, 32'd0);
        @(negedge sclk);
        s_rst_n = 1'b1;
        repeat (6) begin
            @(negedge sclk);
            check("reinit_no_grant", {31'd0, wr_en | rd_en}, 32'd0);
            check("reinit_mux", {28'd0, sdram_cmd}, {28'd0, C_INIT_CMD});
        end
        push_wr(13'h0aaa);
        flag_init_end = 1'b1;
        wait_grant(1'b1, "reinit_grant", n);
        check("reinit_grant_delay", n, 32'd2);
        wr_trig_req = 1'b0;
        release_bus(1'b1, 1);
        check("reinit_ref_req", {31'd0, ref_req}, 32'd0);

        repeat (2) @(negedge sclk);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sdram_arbit
`default_nettype wire
